led_tick_gen: RTL

- Parametrised LED-rate generator for the LED controller; successor to the single-bit-speed LED clock divider.
- Produces a square-wave LED strobe (clk_show) and a one-cycle tick enable from the system clock.
- Four speed modes: three fixed divisors and one runtime-programmable divisor.
- Speed changes apply only at a half-period boundary, so clk_show never glitches; a freeze and a synchronous restart are added.

---
 rtl/led_tick_gen.sv | 101 ++++++++++
 1 files changed

// File: rtl/led_tick_gen.sv
// led_tick_gen
// ------------
// LED-rate generator. Divides the system clock into a square-wave LED strobe
// (clk_show) and a one-cycle tick that fires on every clk_show toggle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         count enable; low freezes counter, clk_show, cur_speed and the
//              active divisor (tick is forced low while frozen)
//   restart    synchronous restart, active high, wins over en
//   speed      mode select: 0..2 pick DIV0..DIV2, 3 picks div_in
//   div_in     programmable half-period used when speed == 3
//   clk_show   LED strobe, toggles every active half-period
//   tick       one-cycle pulse on each clk_show toggle
//   cur_speed  mode currently in force
//
// The active divisor is a registered copy of the selected source. It is only
// reloaded at a half-period boundary (terminal count) or on restart, so a
// speed or div_in change never shortens or stretches the half-period that is
// already in progress, and clk_show never glitches. All outputs are flops.

module led_tick_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV0  = 11,
  parameter int unsigned DIV1  = 41,
  parameter int unsigned DIV2  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [1:0]       speed,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_show,
  output logic             tick,
  output logic [1:0]       cur_speed
);

  localparam logic [CNT_W-1:0] DIV0_V = CNT_W'(DIV0);
  localparam logic [CNT_W-1:0] DIV1_V = CNT_W'(DIV1);
  localparam logic [CNT_W-1:0] DIV2_V = CNT_W'(DIV2);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  // A zero half-period is meaningless; treat it as one cycle.
  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE_V : v;
  endfunction

  localparam logic [CNT_W-1:0] DIV_RST = clamp(DIV0_V);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] sel_div;
  logic             terminal;

  // Divisor source for the next load point, already clamped.
  always_comb begin
    sel_div = DIV_RST;
    case (speed)
      2'd0:    sel_div = clamp(DIV0_V);
      2'd1:    sel_div = clamp(DIV1_V);
      2'd2:    sel_div = clamp(DIV2_V);
      default: sel_div = clamp(div_in);
    endcase
  end

  // div_q is never 0, so div_q - 1 cannot wrap.
  assign terminal = (cnt_q == (div_q - ONE_V));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      div_q     <= DIV_RST;
      clk_show  <= 1'b0;
      tick      <= 1'b0;
      cur_speed <= 2'd0;
    end else if (restart) begin
      cnt_q     <= '0;
      div_q     <= sel_div;
      clk_show  <= 1'b0;
      tick      <= 1'b0;
      cur_speed <= speed;
    end else if (en) begin
      if (terminal) begin
        cnt_q     <= '0;
        div_q     <= sel_div;
        clk_show  <= ~clk_show;
        tick      <= 1'b1;
        cur_speed <= speed;
      end else begin
        cnt_q <= cnt_q + ONE_V;
        tick  <= 1'b0;
      end
    end else begin
      // Frozen: everything holds except tick, which must not stretch.
      tick <= 1'b0;
    end
  end

endmodule
